// File: rtl/sdram_pkg.sv
// Shared SDRAM command definitions: default geometry, address-width helper, command record.
package sdram_pkg;
  localparam int ROW_BITS_D  = 13;
  localparam int COL_BITS_D  = 9;
  localparam int BANK_BITS_D = 2;
  localparam int DATA_W_D    = 16;

  function automatic int addr_w(input int row_bits, input int col_bits, input int bank_bits);
    return row_bits + col_bits + bank_bits;
  endfunction

  localparam int AW_D = addr_w(ROW_BITS_D, COL_BITS_D, BANK_BITS_D);

  typedef struct packed {
    logic                    write;
    logic [AW_D-1:0]         addr;
    logic [DATA_W_D-1:0]     wdata;
    logic [DATA_W_D/8-1:0]   mask;
  } sdram_cmd_t;
endpackage

// File: rtl/sdram_cmd_stage_r.sv
// Optional one-cycle capture register between host port and command queue.
module sdram_cmd_stage_r #(
  parameter int W      = 8,
  parameter int IN_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data
);
  generate
    if (IN_REG != 0) begin : g_reg
      logic         r_vld;
      logic [W-1:0] r_data;

      // Stage always drains next cycle; upstream level check guarantees queue room.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_vld <= 1'b0;
        else     r_vld <= i_vld;
      end

      always_ff @(posedge clk) begin
        if (i_vld) r_data <= i_data;
      end

      assign o_vld  = r_vld;
      assign o_data = r_data;
    end else begin : g_byp
      assign o_vld  = i_vld;
      assign o_data = i_data;
    end
  endgenerate
endmodule

// File: rtl/sdram_cmd_fifo.sv
// DEPTH-entry command queue between host request port and the SDRAM controller FSM.
module sdram_cmd_fifo
  import sdram_pkg::*;
#(
  parameter  int ROW_BITS  = ROW_BITS_D,
  parameter  int COL_BITS  = COL_BITS_D,
  parameter  int BANK_BITS = BANK_BITS_D,
  parameter  int DATA_W    = DATA_W_D,
  parameter  int DEPTH     = 4,
  parameter  int IN_REG    = 1,
  localparam int AW        = addr_w(ROW_BITS, COL_BITS, BANK_BITS),
  localparam int MW        = DATA_W / 8,
  localparam int LW        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [MW-1:0]     cmd_mask,
  input  logic              pop,
  output logic              head_valid,
  output logic              head_write,
  output logic [AW-1:0]     head_addr,
  output logic [DATA_W-1:0] head_wdata,
  output logic [MW-1:0]     head_mask,
  output logic [LW-1:0]     level,
  input  logic              err_clr,
  output logic              pop_err
);
  typedef struct packed {
    logic              write;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] wdata;
    logic [MW-1:0]     mask;
  } cmd_t;

  localparam int CW = $bits(cmd_t);
  localparam int PW = $clog2(DEPTH);

  cmd_t          w_in, w_push_cmd, w_head;
  logic [CW-1:0] w_push_bits;
  logic          w_accept, w_push, w_vpop;

  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [LW-1:0] r_qcnt, r_level;
  logic          r_pop_err;
  cmd_t          r_mem [DEPTH];

  // level already includes the staged beat, so ready never looks at same-cycle pop.
  assign cmd_ready = ~rst & (r_level < LW'(DEPTH));
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_in      = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, mask: cmd_mask};

  sdram_cmd_stage_r #(.W(CW), .IN_REG(IN_REG)) u_stage (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (w_accept),
    .i_data (w_in),
    .o_vld  (w_push),
    .o_data (w_push_bits)
  );

  assign w_push_cmd = cmd_t'(w_push_bits);
  assign head_valid = (r_qcnt != '0);
  assign w_vpop     = pop & head_valid;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_cmd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_qcnt    <= '0;
      r_level   <= '0;
      r_pop_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_vpop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_qcnt  <= r_qcnt + LW'(w_push) - LW'(w_vpop);
      r_level <= r_level + LW'(w_accept) - LW'(w_vpop);
      // A new error wins over a same-cycle clear.
      if (pop & ~head_valid) r_pop_err <= 1'b1;
      else if (err_clr)      r_pop_err <= 1'b0;
    end
  end

  // Storage is not reset; gating keeps head fields at zero whenever the queue is empty.
  assign w_head     = head_valid ? r_mem[r_rd_ptr] : '0;
  assign head_write = w_head.write;
  assign head_addr  = w_head.addr;
  assign head_wdata = w_head.wdata;
  assign head_mask  = w_head.write ? w_head.mask : '0;
  assign level      = r_level;
  assign pop_err    = r_pop_err;
endmodule

// File: tb/tb_sdram_cmd_fifo.sv
// Scoreboard bench for sdram_cmd_fifo: random host traffic and pops against a queue model.
module tb_sdram_cmd_fifo;
  import sdram_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int AW    = AW_D;
  localparam int DW    = DATA_W_D;
  localparam int MW    = DW / 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_mask;
  logic          pop, head_valid, head_write;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_wdata;
  logic [MW-1:0] head_mask;
  logic [LW-1:0] level;
  logic          err_clr, pop_err;

  sdram_cmd_fifo #(.DEPTH(DEPTH), .IN_REG(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .pop(pop), .head_valid(head_valid), .head_write(head_write), .head_addr(head_addr),
    .head_wdata(head_wdata), .head_mask(head_mask), .level(level),
    .err_clr(err_clr), .pop_err(pop_err)
  );

  always #5 clk = ~clk;

  typedef struct { sdram_cmd_t c; int cyc; } exp_t;
  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic m_perr = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: every accepted command is in flight until popped, and becomes visible LAT cycles after accept.
  always @(negedge clk) begin
    logic exp_hv;
    sdram_cmd_t h;
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_perr = 1'b0;
    end else begin
      exp_hv = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + LAT);
      chk("level", 64'(level), 64'(exp_q.size()));
      chk("cmd_ready", 64'(cmd_ready), 64'(exp_q.size() < DEPTH));
      chk("head_valid", 64'(head_valid), 64'(exp_hv));
      chk("pop_err", 64'(pop_err), 64'(m_perr));
      if (exp_hv) begin
        h = exp_q[0].c;
        chk("head_write", 64'(head_write), 64'(h.write));
        chk("head_addr", 64'(head_addr), 64'(h.addr));
        chk("head_wdata", 64'(head_wdata), 64'(h.wdata));
        chk("head_mask", 64'(head_mask), h.write ? 64'(h.mask) : 64'd0);
      end
      if (pop && exp_hv) void'(exp_q.pop_front());
      if (pop && !exp_hv) m_perr = 1'b1;
      else if (err_clr)   m_perr = 1'b0;
      if (cmd_valid && cmd_ready)
        exp_q.push_back('{c: '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, mask: cmd_mask}, cyc: cyc});
    end
  end

  task automatic rand_cmd();
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    cmd_mask  = MW'($urandom);
  endtask

  // Host holds a command until accepted; vp/pp are percent chances of a new command / a pop.
  task automatic run(input int vp, input int pp, input int n);
    logic acc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      acc = cmd_valid && cmd_ready;
      @(posedge clk); #1;
      if (acc || !cmd_valid) begin
        if (int'($urandom_range(99)) < vp) begin rand_cmd(); cmd_valid = 1'b1; end
        else cmd_valid = 1'b0;
      end
      pop     = int'($urandom_range(99)) < pp;
      err_clr = $urandom_range(99) < 5;
    end
    @(posedge clk); #1;
    pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic drain();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 30 && level != 0; i++) begin
      pop = head_valid;
      @(posedge clk); #1;
    end
    pop = 1'b0;
    @(negedge clk);
    chk("drain_level", 64'(level), 64'd0);
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rand_cmd(); cmd_valid = 1'b1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_mask = '0; pop = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_head_valid", 64'(head_valid), 64'd0);
    chk("rst_head_addr", 64'(head_addr), 64'd0);
    chk("rst_pop_err", 64'(pop_err), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", 64'(cmd_ready), 64'd1);

    // Single write, two-cycle latency to head.
    @(posedge clk); #1;
    cmd_write = 1'b1; cmd_addr = 24'h123456; cmd_wdata = 16'hBEEF; cmd_mask = 2'b01; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("lat1_head_valid", 64'(head_valid), 64'd0);
    @(negedge clk);
    chk("lat2_head_valid", 64'(head_valid), 64'd1);
    chk("single_addr", 64'(head_addr), 64'h123456);
    chk("single_wdata", 64'(head_wdata), 64'hBEEF);
    chk("single_mask", 64'(head_mask), 64'd1);
    @(posedge clk); #1 pop = 1'b1;
    @(posedge clk); #1 pop = 1'b0;

    // Fill to DEPTH, then let the held fifth command through.
    run(100, 0, 8);
    @(negedge clk);
    chk("full_level", 64'(level), 64'(DEPTH));
    chk("full_ready", 64'(cmd_ready), 64'd0);
    run(0, 60, 20);
    drain();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;

    // Steady accept+pop at level 2.
    send_n(2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lvl2_start", 64'(level), 64'd2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rand_cmd(); cmd_valid = 1'b1; pop = 1'b1;
    end
    @(posedge clk); #1 cmd_valid = 1'b0; pop = 1'b0;
    @(negedge clk);
    chk("lvl2_end", 64'(level), 64'd2);
    drain();

    // Pop on empty queue.
    @(posedge clk); #1 pop = 1'b1;
    @(posedge clk); #1 pop = 1'b0;
    @(negedge clk);
    chk("empty_pop_err", 64'(pop_err), 64'd1);
    chk("empty_pop_level", 64'(level), 64'd0);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr", 64'(pop_err), 64'd0);

    // Read with mask set reports mask zero.
    @(posedge clk); #1;
    cmd_write = 1'b0; cmd_addr = 24'h0ABCDE; cmd_wdata = 16'h1234; cmd_mask = 2'b11; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("read_head_valid", 64'(head_valid), 64'd1);
    chk("read_mask", 64'(head_mask), 64'd0);
    drain();

    // Wrap and random ordering.
    run(60, 50, 400);
    drain();

    // Reset mid-traffic with three queued entries.
    send_n(3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_level", 64'(level), 64'd3);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_head_valid", 64'(head_valid), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);
    chk("post_rst_head_valid", 64'(head_valid), 64'd0);
    run(60, 50, 60);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
